// File: rtl/simd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : simd_pkg
// Brief   : Shared lane/vector types and serializer states for the SIMD path.
// Revision: 1.0 - initial release
// ============================================================================
package simd_pkg;

    localparam int c_LANES  = 4;
    localparam int c_LANE_W = 16;

    typedef logic [c_LANE_W-1:0] lane_t;
    typedef lane_t [c_LANES-1:0] vec_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ser_state_t;

endpackage : simd_pkg
`default_nettype wire

// File: rtl/simd_vec_fifo.sv
`default_nettype none
// ============================================================================
// Module  : simd_vec_fifo
// Brief   : DEPTH-entry vector FIFO with combinational head read and count.
// Revision: 1.0 - initial release
// ============================================================================
module simd_vec_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic                       i_pop,
    input  wire logic [W-1:0]               i_wdata,
    output logic      [W-1:0]               o_rdata,
    output logic      [$clog2(DEPTH):0]     o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [W-1:0]      r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic              w_push;
    logic              w_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push  = i_push && (r_count != c_FULL);
    assign w_pop   = i_pop  && (r_count != '0);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : simd_vec_fifo
`default_nettype wire

// File: rtl/simd_result_serializer.sv
`default_nettype none
// ============================================================================
// Module  : simd_result_serializer
// Brief   : Buffers SIMD result vectors and streams them out lane by lane.
// Revision: 1.0 - initial release
// ============================================================================
module simd_result_serializer
    import simd_pkg::*;
#(
    parameter int LANES  = c_LANES,
    parameter int LANE_W = c_LANE_W,
    parameter int DEPTH  = 4
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        enable,
    input  wire logic                        in_valid,
    output logic                             in_ready,
    input  wire logic [LANES*LANE_W-1:0]     in_data,
    output logic                             out_valid,
    input  wire logic                        out_ready,
    output logic      [LANE_W-1:0]           out_data,
    output logic      [$clog2(LANES)-1:0]    out_lane,
    output logic                             out_last,
    output logic      [$clog2(DEPTH):0]      vec_count
);

    localparam int c_LW = $clog2(LANES);
    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam logic [c_LW-1:0] c_LAST_LANE = c_LW'(LANES - 1);
    localparam logic [c_CW-1:0] c_FULL      = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

    ser_state_t           r_state;
    logic                 r_valid;
    logic [c_LW-1:0]      r_lane;
    logic                 r_last;

    logic [LANES*LANE_W-1:0] w_head;
    logic [LANE_W-1:0]       w_lanes [LANES];
    logic [c_CW-1:0]         w_count;
    logic [c_LW-1:0]         w_lane_nxt;
    logic                    w_in_ready;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_more;

    assign w_in_ready = enable && !rst && (w_count != c_FULL);
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = r_valid && out_ready && r_last;
    // A vector remains after this pop if another is queued or one arrives now.
    assign w_more     = (w_count != c_ONE) || w_push;
    assign w_lane_nxt = r_lane + 1'b1;

    simd_vec_fifo #(
        .W     (LANES * LANE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (in_data),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane_unpack
        assign w_lanes[g] = w_head[g*LANE_W +: LANE_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_lane  <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_state <= EMIT;
                        r_valid <= 1'b1;
                        r_lane  <= '0;
                        r_last  <= (c_LAST_LANE == '0);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (r_last) begin
                            r_lane <= '0;
                            r_last <= (c_LAST_LANE == '0);
                            if (!w_more) begin
                                r_state <= IDLE;
                                r_valid <= 1'b0;
                            end
                        end else begin
                            r_lane <= w_lane_nxt;
                            r_last <= (w_lane_nxt == c_LAST_LANE);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_lane  = r_lane;
    assign out_last  = r_valid && r_last;
    assign out_data  = r_valid ? w_lanes[r_lane] : '0;
    assign vec_count = w_count;

endmodule : simd_result_serializer
`default_nettype wire
